// File: rtl/system_in_if.sv
// Host-to-input-stage job word stream: 32-bit words with a valid/ready handshake.
// The host drives data and valid; the input stage drives ready.
interface system_in_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/system_in.sv
// Input stage of the nonce-search datapath: collects a header+target job from the host,
// holds it for the hash core, pulses start, and waits for finish or timeout.
module system_in #(
  parameter int HDR_WORDS = 19,
  parameter int CNT_W     = 5,
  parameter int TIMEOUT   = 1048576,
  parameter int TMO_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  system_in_if.slave              host,
  input  logic                    abort,
  input  logic                    core_finished,
  output logic [HDR_WORDS*32-1:0] header_out,
  output logic [31:0]             target_out,
  output logic                    start,
  output logic                    busy,
  output logic                    job_done,
  output logic                    timeout_err,
  output logic [CNT_W-1:0]        word_count
);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(HDR_WORDS);

  state_t           state;
  logic             armed;
  logic [TMO_W-1:0] timer;
  logic             xfer;

  // NOTE: ready is a pure decode of the registered state, so it rises the moment reset asserts.
  assign host.data_ready = (state == IDLE) || (state == LOAD);
  assign xfer            = host.data_valid && host.data_ready;

  // NOTE: all state uses non-blocking assignments; start/job_done default low each cycle
  // so they are single-cycle registered pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      header_out  <= '0;
      target_out  <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      job_done    <= 1'b0;
      timeout_err <= 1'b0;
      word_count  <= '0;
      armed       <= 1'b0;
      timer       <= '0;
    end else begin
      start    <= 1'b0;
      job_done <= 1'b0;
      if (abort) begin
        // Cancel wins over a same-edge transfer; loaded header words are kept.
        state      <= IDLE;
        word_count <= '0;
        armed      <= 1'b0;
        timer      <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (xfer) begin
              header_out[31:0] <= host.data_in;
              word_count       <= CNT_W'(1);
              timeout_err      <= 1'b0;
              state            <= LOAD;
            end
          end
          LOAD: begin
            if (xfer) begin
              if (word_count < LAST_HDR) begin
                header_out[32*int'(word_count) +: 32] <= host.data_in;
                word_count                            <= word_count + CNT_W'(1);
              end else begin
                target_out <= host.data_in;
                start      <= 1'b1;
                busy       <= 1'b1;
                state      <= START;
              end
            end
          end
          START: begin
            armed <= 1'b0;
            timer <= '0;
            state <= RUN;
          end
          RUN: begin
            timer <= timer + TMO_W'(1);
            // A low finished flag proves the core has seen this job; only then trust a high one.
            if (!core_finished) armed <= 1'b1;
            if (armed && core_finished) begin
              job_done   <= 1'b1;
              busy       <= 1'b0;
              word_count <= '0;
              state      <= DONE;
            end else if (TIMEOUT != 0 && timer == TMO_LAST) begin
              timeout_err <= 1'b1;
              job_done    <= 1'b1;
              busy        <= 1'b0;
              word_count  <= '0;
              state       <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_system_in.sv
// Self-checking bench for system_in: directed job scenarios plus randomized traffic,
// compared every cycle against a job-level behavioural model.
module tb_system_in;

  localparam int HDR = 19;
  localparam int CW  = 5;
  localparam int TMO = 16;
  localparam int W   = HDR * 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort = 1'b0;
  logic          core_finished = 1'b1;
  logic [W-1:0]  header_out;
  logic [31:0]   target_out;
  logic          start, busy, job_done, timeout_err;
  logic [CW-1:0] word_count;

  system_in_if bus ();

  system_in #(.HDR_WORDS(HDR), .CNT_W(CW), .TIMEOUT(TMO), .TMO_W(32)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .host          (bus),
    .abort         (abort),
    .core_finished (core_finished),
    .header_out    (header_out),
    .target_out    (target_out),
    .start         (start),
    .busy          (busy),
    .job_done      (job_done),
    .timeout_err   (timeout_err),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (job-level phases) ----------------
  typedef enum {M_IDLE, M_LOAD, M_START, M_RUN, M_DONE} mphase_t;
  mphase_t     m_phase;
  int          m_cnt;
  logic [31:0] m_hdr [HDR];
  logic [31:0] m_tgt;
  logic        m_terr;
  int          m_runs;
  logic        m_seen_low;

  always @(posedge clk or negedge rst_n) begin : model
    automatic mphase_t     ph   = m_phase;
    automatic int          cnt  = m_cnt;
    automatic logic [31:0] h [HDR] = m_hdr;
    automatic logic [31:0] tg   = m_tgt;
    automatic logic        te   = m_terr;
    automatic int          runs = m_runs;
    automatic logic        seen = m_seen_low;
    if (!rst_n) begin
      for (int k = 0; k < HDR; k++) h[k] = '0;
      ph = M_IDLE; cnt = 0; tg = '0; te = 1'b0; runs = 0; seen = 1'b0;
    end else if (abort) begin
      ph = M_IDLE; cnt = 0; runs = 0; seen = 1'b0;
    end else begin
      case (ph)
        M_IDLE: if (bus.data_valid) begin
          h[0] = bus.data_in; cnt = 1; te = 1'b0; ph = M_LOAD;
        end
        M_LOAD: if (bus.data_valid) begin
          if (cnt < HDR) begin h[cnt] = bus.data_in; cnt++; end
          else begin tg = bus.data_in; ph = M_START; end
        end
        M_START: begin ph = M_RUN; runs = 0; seen = 1'b0; end
        M_RUN: begin
          if (seen && core_finished) begin ph = M_DONE; cnt = 0; end
          else if (TMO != 0 && runs + 1 == TMO) begin ph = M_DONE; cnt = 0; te = 1'b1; end
          else begin runs++; if (!core_finished) seen = 1'b1; end
        end
        M_DONE: ph = M_IDLE;
        default: ph = M_IDLE;
      endcase
    end
    m_phase    <= ph;
    m_cnt      <= cnt;
    m_hdr      <= h;
    m_tgt      <= tg;
    m_terr     <= te;
    m_runs     <= runs;
    m_seen_low <= seen;
  end

  function automatic logic [W-1:0] model_hdr();
    logic [W-1:0] v;
    for (int k = 0; k < HDR; k++) v[32*k +: 32] = m_hdr[k];
    return v;
  endfunction

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready",   W'(bus.data_ready), W'(m_phase == M_IDLE || m_phase == M_LOAD));
      check("start",   W'(start),          W'(m_phase == M_START));
      check("busy",    W'(busy),           W'(m_phase == M_START || m_phase == M_RUN));
      check("done",    W'(job_done),       W'(m_phase == M_DONE));
      check("tmo_err", W'(timeout_err),    W'(m_terr));
      check("wcount",  W'(word_count),     W'(m_cnt));
      check("target",  W'(target_out),     W'(m_tgt));
      check("header",  header_out,         model_hdr());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    bus.data_in    = d;
    bus.data_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.data_ready) begin
        tick();
        bus.data_valid = 1'b0;
        return;
      end
      tick();
    end
    bus.data_valid = 1'b0;
    total++;
    bad++;
    $display("FAIL send_wait: ready never rose, got 0 expected 1");
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!job_done && n < 100) begin
      tick();
      n++;
    end
  endtask

  logic [W-1:0] exp_hdr;
  logic [31:0]  saved [9];
  int           n, acc;
  logic         rdy;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    #1;
    check("rst_ready",  W'(bus.data_ready), W'(1'b1));
    check("rst_wcount", W'(word_count),     W'(0));
    check("rst_header", header_out,         '0);
    check("rst_start",  W'(start),          W'(1'b0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // 1: back-to-back load, finished held high
    core_finished = 1'b1;
    for (int k = 0; k < HDR; k++) send(32'(k));
    send(32'h0000_FFFF);
    for (int k = 0; k < HDR; k++) exp_hdr[32*k +: 32] = 32'(k);
    check("t1_start",  W'(start),      W'(1'b1));
    check("t1_busy",   W'(busy),       W'(1'b1));
    check("t1_target", W'(target_out), W'(32'h0000_FFFF));
    check("t1_header", header_out,     exp_hdr);
    tick();
    check("t1_start_off", W'(start), W'(1'b0));
    check("t1_busy_run",  W'(busy),  W'(1'b1));

    // 2: stale finished flag ignored, then low-high completes
    repeat (10) begin
      tick();
      check("t2_no_done", W'(job_done), W'(1'b0));
    end
    core_finished = 1'b0;
    tick();
    core_finished = 1'b1;
    tick();
    check("t2_done",    W'(job_done),    W'(1'b1));
    check("t2_tmo_err", W'(timeout_err), W'(1'b0));
    tick();
    check("t2_done_off", W'(job_done), W'(1'b0));

    // 3: timeout after 16 RUN cycles
    core_finished = 1'b0;
    for (int k = 0; k <= HDR; k++) send($urandom);
    wait_done(n);
    check("t3_latency", W'(n),           W'(17));
    check("t3_tmo_err", W'(timeout_err), W'(1'b1));
    send(32'h1234_5678);
    check("t3_err_clr", W'(timeout_err), W'(1'b0));
    check("t3_wcount",  W'(word_count),  W'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // 4: data_valid toggling during load
    acc = 0;
    n   = 0;
    while (acc < HDR + 1 && n < 200) begin
      bus.data_valid = n[0] ? 1'b0 : 1'b1;
      bus.data_in    = $urandom;
      rdy            = bus.data_ready;
      tick();
      if (bus.data_valid && rdy) acc++;
      check("t4_wcount", W'(word_count), W'(acc > HDR ? HDR : acc));
      check("t4_start",  W'(start),      W'(acc == HDR + 1));
      n++;
    end
    bus.data_valid = 1'b0;
    tick();
    core_finished = 1'b1;
    wait_done(n);
    check("t4_done", W'(job_done), W'(1'b1));
    tick();

    // 5: abort on the 10th transfer
    for (int k = 0; k < 9; k++) begin
      saved[k] = $urandom;
      send(saved[k]);
    end
    bus.data_in    = 32'hDEAD_BEEF;
    bus.data_valid = 1'b1;
    abort          = 1'b1;
    tick();
    abort          = 1'b0;
    bus.data_valid = 1'b0;
    check("t5_wcount", W'(word_count),     W'(0));
    check("t5_ready",  W'(bus.data_ready), W'(1'b1));
    check("t5_start",  W'(start),          W'(1'b0));
    for (int k = 0; k < 9; k++) check("t5_kept", W'(header_out[32*k +: 32]), W'(saved[k]));
    tick();
    check("t5_no_start", W'(start), W'(1'b0));
    for (int k = 0; k <= HDR; k++) send($urandom);
    check("t5_reload", W'(start), W'(1'b1));
    core_finished = 1'b0;
    tick();
    tick();
    core_finished = 1'b1;
    wait_done(n);
    check("t5_done", W'(job_done), W'(1'b1));
    tick();

    // 6: asynchronous reset mid-RUN
    core_finished = 1'b0;
    for (int k = 0; k <= HDR; k++) send($urandom);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy",   W'(busy),           W'(1'b0));
    check("t6_start",  W'(start),          W'(1'b0));
    check("t6_done",   W'(job_done),       W'(1'b0));
    check("t6_ready",  W'(bus.data_ready), W'(1'b1));
    check("t6_wcount", W'(word_count),     W'(0));
    check("t6_header", header_out,         '0);
    check("t6_target", W'(target_out),     W'(0));
    check("t6_tmoerr", W'(timeout_err),    W'(1'b0));
    #4 rst_n = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.data_valid = ($urandom_range(0, 3) != 0);
      bus.data_in    = $urandom;
      abort          = ($urandom_range(0, 63) == 0);
      core_finished  = $urandom_range(0, 1) == 1;
      tick();
    end
    abort          = 1'b0;
    bus.data_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
